// File: rtl/fpu_share_ctrl.sv
// ---------------------------------------------------------------------------
// fpu_share_ctrl
//
// Lets two requesters share one fixed-latency FPU datapath. At most one
// operation is issued per cycle, and the two requesters take turns when both
// want the FPU. Each issued op carries a one-bit requester tag down a
// C_LATENCY-deep tracking pipe. When the op completes, its result and
// exception flags go back to that requester. Each requester has its own set
// of sticky exception flags. A flush FSM stops new issue and waits for the
// pipe to drain, so a context switch can happen cleanly.
//
// Ports
//   Clk_CI, Rst_RI     clock (rising edge); asynchronous active-high reset
//   Req_Valid_SI       per-requester request valid
//   Req_Ready_SO       per-requester accept (at most one-hot)
//   Req_Op_DI          op of requester i at [i*CMD +: CMD]
//   Req_OpA_DI/OpB_DI  operands of requester i at [i*32 +: 32]
//   Fpu_Valid_SO       issue strobe towards the FPU (registered)
//   Fpu_Op/OpA/OpB_DO  issued op and operands (hold while not issuing)
//   Fpu_Res_DI         FPU result, C_LATENCY cycles after the issue strobe
//   Fpu_Flags_DI       {IV,Inf,OF,UF,IX}, same timing as Fpu_Res_DI
//   Resp_Valid_SO      one-cycle completion pulse per requester
//   Resp_Res_DO        completing result (shared by both requesters)
//   Resp_Flags_DO      flags of the completing op only
//   Sticky_DO          accumulated flags, requester i at [i*5 +: 5]
//   Sticky_Clr_SI      per-requester sticky clear
//   Flush_SI           drain request (level)
//   Flush_Done_SO      one-cycle pulse once the drain has finished
// ---------------------------------------------------------------------------

package fpu_defs;
  // Width of the FPU command field used by the requesters and the datapath.
  localparam int C_FPU01_CMD = 4;
  // Encoding of a floating-point add on that command field.
  localparam logic [C_FPU01_CMD-1:0] C_FPU_ADD_OP = '0;
endpackage

module fpu_share_ctrl #(
  parameter int C_LATENCY = 4
) (
  input  logic                               Clk_CI,
  input  logic                               Rst_RI,
  input  logic [1:0]                         Req_Valid_SI,
  output logic [1:0]                         Req_Ready_SO,
  input  logic [2*fpu_defs::C_FPU01_CMD-1:0] Req_Op_DI,
  input  logic [63:0]                        Req_OpA_DI,
  input  logic [63:0]                        Req_OpB_DI,
  output logic                               Fpu_Valid_SO,
  output logic [fpu_defs::C_FPU01_CMD-1:0]   Fpu_Op_DO,
  output logic [31:0]                        Fpu_OpA_DO,
  output logic [31:0]                        Fpu_OpB_DO,
  input  logic [31:0]                        Fpu_Res_DI,
  input  logic [4:0]                         Fpu_Flags_DI,
  output logic [1:0]                         Resp_Valid_SO,
  output logic [31:0]                        Resp_Res_DO,
  output logic [4:0]                         Resp_Flags_DO,
  output logic [9:0]                         Sticky_DO,
  input  logic [1:0]                         Sticky_Clr_SI,
  input  logic                               Flush_SI,
  output logic                               Flush_Done_SO
);

  localparam int Cmd = fpu_defs::C_FPU01_CMD;

  // Every pipe stage except the output stage. An entry in the output stage
  // completes in the current cycle, so it no longer holds up a drain.
  localparam logic [C_LATENCY-1:0] EarlyMask = {C_LATENCY{1'b1}} >> 1;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StDone,
    StHold
  } state_e;

  state_e               state_q;
  logic                 flushDone_q;
  logic                 rrPtr_q;

  logic [1:0]           grant_d;
  logic                 issueTag_d;
  logic [Cmd-1:0]       issueOp_d;
  logic [31:0]          issueA_d;
  logic [31:0]          issueB_d;

  logic                 issueValid_q;
  logic                 issueTag_q;
  logic [Cmd-1:0]       issueOp_q;
  logic [31:0]          issueA_q;
  logic [31:0]          issueB_q;

  logic [C_LATENCY-1:0] pipeValid_q;
  logic [C_LATENCY-1:0] pipeTag_q;

  logic                 respValid;
  logic                 respTag;
  logic                 drainBusy;

  logic [9:0]           sticky_q;
  logic [9:0]           sticky_d;

  // Grant logic. Issue happens only in RUN with no flush request present, so
  // a flush shuts the door in the same cycle it is raised. When both
  // requesters are valid, the pointer chooses between them. Ready is also
  // gated by reset, so it reads 0 while reset is held.
  always_comb begin
    grant_d = 2'b00;
    if (!Rst_RI && (state_q == StRun) && !Flush_SI) begin
      case (Req_Valid_SI)
        2'b01:   grant_d = 2'b01;
        2'b10:   grant_d = 2'b10;
        2'b11:   grant_d = rrPtr_q ? 2'b10 : 2'b01;
        default: grant_d = 2'b00;
      endcase
    end
  end

  assign Req_Ready_SO = grant_d;

  // Select the granted requester's op and operands.
  assign issueTag_d = grant_d[1];
  assign issueOp_d  = grant_d[1] ? Req_Op_DI[Cmd +: Cmd] : Req_Op_DI[0 +: Cmd];
  assign issueA_d   = grant_d[1] ? Req_OpA_DI[32 +: 32]  : Req_OpA_DI[0 +: 32];
  assign issueB_d   = grant_d[1] ? Req_OpB_DI[32 +: 32]  : Req_OpB_DI[0 +: 32];

  // Issue register and round-robin pointer. The data fields load only on a
  // grant, so the FPU sees stable operands between issues. After a grant, the
  // pointer moves to the requester that was not served.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      issueValid_q <= 1'b0;
      issueTag_q   <= 1'b0;
      issueOp_q    <= '0;
      issueA_q     <= '0;
      issueB_q     <= '0;
      rrPtr_q      <= 1'b0;
    end else begin
      issueValid_q <= |grant_d;
      if (|grant_d) begin
        issueTag_q <= issueTag_d;
        issueOp_q  <= issueOp_d;
        issueA_q   <= issueA_d;
        issueB_q   <= issueB_d;
        rrPtr_q    <= ~issueTag_d;
      end
    end
  end

  assign Fpu_Valid_SO = issueValid_q;
  assign Fpu_Op_DO    = issueOp_q;
  assign Fpu_OpA_DO   = issueA_q;
  assign Fpu_OpB_DO   = issueB_q;

  // Tracking pipe. It is fed from the issue register, not from the handshake.
  // As a result, the output stage lines up with the FPU result C_LATENCY
  // cycles after the issue strobe. Reset empties the pipe, so ops that were
  // in flight during a reset never produce a response.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      pipeValid_q <= '0;
      pipeTag_q   <= '0;
    end else begin
      pipeValid_q[0] <= issueValid_q;
      pipeTag_q[0]   <= issueTag_q;
      for (int k = 1; k < C_LATENCY; k++) begin
        pipeValid_q[k] <= pipeValid_q[k-1];
        pipeTag_q[k]   <= pipeTag_q[k-1];
      end
    end
  end

  assign respValid = pipeValid_q[C_LATENCY-1];
  assign respTag   = pipeTag_q[C_LATENCY-1];

  // The response data is a direct pass-through of the FPU. It is zeroed when
  // no tracked op completes, so random values on the FPU bus never leak out.
  assign Resp_Valid_SO = {respValid & respTag, respValid & ~respTag};
  assign Resp_Res_DO   = respValid ? Fpu_Res_DI   : 32'b0;
  assign Resp_Flags_DO = respValid ? Fpu_Flags_DI : 5'b0;

  // Sticky flag update. The clear is applied first and the new flags are ORed
  // in afterwards, so a response that arrives together with a clear still
  // leaves its flags behind.
  always_comb begin
    sticky_d = '0;
    for (int i = 0; i < 2; i++) begin
      sticky_d[i*5 +: 5] = (Sticky_Clr_SI[i] ? 5'b0 : sticky_q[i*5 +: 5])
                         | (Resp_Valid_SO[i] ? Resp_Flags_DO : 5'b0);
    end
  end

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign Sticky_DO = sticky_q;

  // The pipe counts as drained once nothing is waiting to be issued and no
  // entry sits before the output stage. Any op still in the output stage
  // completes in this cycle.
  assign drainBusy = issueValid_q | (|(pipeValid_q & EarlyMask));

  // Flush FSM. DRAIN always lasts at least one cycle, even for an idle pipe.
  // DONE raises the done pulse for one cycle. HOLD keeps issue blocked while
  // the flush request is still high after the drain has finished.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      state_q     <= StRun;
      flushDone_q <= 1'b0;
    end else begin
      flushDone_q <= 1'b0;
      case (state_q)
        StRun: begin
          if (Flush_SI) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (!drainBusy) begin
            state_q     <= StDone;
            flushDone_q <= 1'b1;
          end
        end
        StDone: begin
          state_q <= Flush_SI ? StHold : StRun;
        end
        StHold: begin
          if (!Flush_SI) begin
            state_q <= StRun;
          end
        end
        default: begin
          state_q <= StRun;
        end
      endcase
    end
  end

  assign Flush_Done_SO = flushDone_q;

endmodule
